// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers load/store requests after a fixed
// number of wait states, with a one-cycle ready strobe and an error qualifier.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err,
    output logic        stall
);

    localparam int unsigned CNT_W = ($clog2(WAIT_CYCLES + 1) < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int unsigned IDX_W = ($clog2(DEPTH_WORDS) < 1) ? 1 : $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;

    logic             req_err;
    logic             lat_write;
    logic             lat_err;
    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      lat_data;

    logic             resp_write;
    logic             resp_err;
    logic [IDX_W-1:0] resp_idx;
    logic             enter_resp;

    logic [31:0]      mem [DEPTH_WORDS];

    // Rejection rules: conflicting op, misaligned byte address, word index past the end
    assign req_err = (MemRead & MemWrite)
                   | (address[1:0] != 2'b00)
                   | ({2'b00, address[31:2]} >= 32'(DEPTH_WORDS));

    // Response attributes come from the live request when RESP follows IDLE directly
    assign resp_write = accept ? MemWrite : lat_write;
    assign resp_err   = accept ? req_err : lat_err;
    assign resp_idx   = accept ? address[IDX_W+1:2] : lat_idx;
    assign enter_resp = (state_next == S_RESP);

    assign stall = (MemRead | MemWrite) & ~ready;

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, single RESP cycle
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (MemRead | MemWrite) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Capture the request when it is accepted; later input changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_data  <= '0;
        end else if (accept) begin
            lat_write <= MemWrite;
            lat_err   <= req_err;
            lat_idx   <= address[IDX_W+1:2];
            lat_data  <= writedata;
        end
    end

    // Registered response: strobe on entry to RESP, load data only for good reads
    always_ff @(posedge clk) begin
        if (reset) begin
            ready    <= 1'b0;
            err      <= 1'b0;
            readdata <= '0;
        end else begin
            ready <= enter_resp;
            err   <= enter_resp & resp_err;
            if (enter_resp && !resp_err && !resp_write) begin
                readdata <= mem[resp_idx];
            end
        end
    end

    // Good writes commit on the edge leaving RESP; reset cancels the commit
    always_ff @(posedge clk) begin
        if (!reset && state == S_RESP && lat_write && !lat_err) begin
            mem[lat_idx] <= lat_data;
        end
    end

endmodule
